text_buffer: RTL and testbench
==============================

Name: text_buffer

Overview:
- Parametrised successor to the single-field tile buffer: an H_TILES x V_TILES character store where each tile holds a character code plus a colour/attribute field.
- Adds a hardware fill engine (clear screen) and a hardware scroll-up (circular row offset plus bottom-row clear).
- Sits between the host write interface and the VGA character renderer; the renderer read path runs uninterrupted during engine operations.

Parameters:
- H_TILES, 80, tiles per row (640/8)
- V_TILES, 30, tile rows (480/16)
- NUM_TILES, H_TILES*V_TILES, total tiles (2400)
- COL_WIDTH, 7, column index width, ceil(log2(H_TILES))
- ROW_WIDTH, 5, row index width, ceil(log2(V_TILES))
- CHAR_WIDTH, 7, character code width (128 glyphs)
- ATTR_WIDTH, 8, attribute width (4-bit fg, 4-bit bg colour)

Ports:
- clk  in  1  pixel clock, 25 MHz
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  host tile write strobe
- col_w  in  COL_WIDTH  logical column to write
- row_w  in  ROW_WIDTH  logical row to write
- din_char  in  CHAR_WIDTH  character to write
- din_attr  in  ATTR_WIDTH  attribute to write
- col_r  in  COL_WIDTH  logical column to read
- row_r  in  ROW_WIDTH  logical row to read
- dout_char  out  CHAR_WIDTH  registered character read data
- dout_attr  out  ATTR_WIDTH  registered attribute read data
- clr_req  in  1  single-cycle pulse: fill whole screen
- scroll_req  in  1  single-cycle pulse: scroll up one row
- fill_char  in  CHAR_WIDTH  fill character for clear/scroll
- fill_attr  in  ATTR_WIDTH  fill attribute for clear/scroll
- busy  out  1  engine active

Behaviour:
- Reset (asynchronous, active-high): dout_char=0, dout_attr=0, busy=0, FSM=IDLE, row offset=0, fill counters=0. Memory is not reset; it is initialised to all-zero at configuration only.
- Reset mid-operation: abort immediately. Partially filled memory stays as is. Offset returns to 0.
- Address mapping:
  - physical row = row + offset, minus V_TILES if the sum >= V_TILES (compare-subtract, no divider).
  - address = phys_row*H_TILES + col.
- Read:
  - One cycle latency: dout is the tile addressed at edge k, valid after edge k.
  - Active every cycle, including while busy.
  - Read-during-write to the same address returns the old data.
  - col_r >= H_TILES or row_r >= V_TILES returns 0/0.
- Host write:
  - Occurs at the edge where wr_en=1 and busy=0.
  - Ignored when busy=1 or when col_w/row_w is out of range.
- FSM states: IDLE, CLEAR, SCROLL.
- IDLE -> CLEAR: clr_req=1 at edge k.
  - Latch fill_char/fill_attr. Set offset=0. busy=1 after edge k.
  - Writes physical addresses 0..NUM_TILES-1 at edges k+1..k+NUM_TILES.
  - Returns to IDLE and busy=0 after edge k+NUM_TILES, so busy is high for exactly NUM_TILES cycles.
- IDLE -> SCROLL: scroll_req=1 and clr_req=0 at edge k.
  - Latch fill values. Latch old offset.
  - Set offset=(offset+1) wrapping to 0 after V_TILES-1, effective from edge k.
  - Writes physical row old_offset, cols 0..H_TILES-1, at edges k+1..k+H_TILES. busy is high for exactly H_TILES cycles.
  - Net effect: logical row r shows old row r+1; the last logical row shows fill.
- Simultaneous clr_req and scroll_req: clear wins; the scroll is dropped.
- clr_req or scroll_req while busy: ignored, no queueing.
- The engine owns the write port while busy.

Decomposition:
- Package text_buffer_pkg holds:
  - default H_TILES, V_TILES, NUM_TILES
  - the width constants
  - FSM state encoding (IDLE=2'd0, CLEAR=2'd1, SCROLL=2'd2)
- Sub-module tile_ram holds the (CHAR_WIDTH+ATTR_WIDTH)-bit memory:
  - one write port, one registered read port, read-first.
  - zero-initialised.
- The top level holds the FSM, offset register, fill counter, address mapping and range checks.

Test Plan:
- Reset, then write col 5 row 3 char 0x41 attr 0x1F -> reading col 5 row 3 returns 0x41/0x1F one cycle later. Reading col 80 returns 0/0.
- clr_req with fill 0x20/0x07 -> busy high exactly 2400 cycles. A wr_en during busy has no effect. Afterwards all 2400 tiles read 0x20/0x07.
- Write row 0 col 0 = 0x41, row 1 col 0 = 0x42, then scroll_req with fill 0x20/0x07 -> busy high 80 cycles. Then row 0 col 0 reads 0x42, row 28 col 0 reads the old row 29, row 29 reads 0x20/0x07 in all columns.
- 31 consecutive scrolls, then a write/read at row 29 col 79 -> offset wraps to 1, the read returns the written value, and the other rows hold the fill.
- clr_req and scroll_req asserted on the same cycle -> busy for 2400 cycles (clear), offset=0; a later single scroll takes 80 cycles.
- rst pulsed 1000 cycles into a clear -> busy, dout and offset drop to 0 asynchronously; the next clr_req completes normally in 2400 cycles.

Source files
------------

// File: rtl/text_buffer_pkg.sv
// Shared sizes, FSM encoding and row-wrap helper for the text_buffer tile store.
package text_buffer_pkg;

  localparam int H_TILES_DEF   = 80;
  localparam int V_TILES_DEF   = 30;
  localparam int NUM_TILES_DEF = H_TILES_DEF * V_TILES_DEF;

  localparam int COL_WIDTH  = 7;
  localparam int ROW_WIDTH  = 5;
  localparam int CHAR_WIDTH = 7;
  localparam int ATTR_WIDTH = 8;
  localparam int TILE_WIDTH = CHAR_WIDTH + ATTR_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    SCROLL = 2'd2
  } state_e;

  // Compare-subtract wrap of (row + offset) into 0..limit-1; sum is always < 2*limit.
  function automatic logic [ROW_WIDTH-1:0] wrap_row(input logic [ROW_WIDTH:0] sum,
                                                    input logic [ROW_WIDTH:0] limit);
    logic [ROW_WIDTH:0] res;
    if (sum >= limit) begin
      res = sum - limit;
    end else begin
      res = sum;
    end
    return res[ROW_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/text_buffer_tile_ram.sv
// Single-write, single-read tile memory; read port is registered and read-first.
module text_buffer_tile_ram #(
  parameter int DEPTH = 2400,
  parameter int AW    = 12,
  parameter int DW    = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          rvalid_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register: sees pre-write contents on a same-address collision; out-of-range reads give zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= {DW{1'b0}};
    end else if (rvalid_i) begin
      rdata_q <= mem_q[raddr_i];
    end else begin
      rdata_q <= {DW{1'b0}};
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/text_buffer.sv
// Character/attribute tile store with host writes, a clear-screen fill engine and
// hardware scroll-up via a circular row offset; the renderer read port never stalls.
module text_buffer
  import text_buffer_pkg::*;
#(
  parameter int H_TILES   = H_TILES_DEF,
  parameter int V_TILES   = V_TILES_DEF,
  parameter int NUM_TILES = H_TILES * V_TILES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [COL_WIDTH-1:0]  col_w,
  input  logic [ROW_WIDTH-1:0]  row_w,
  input  logic [CHAR_WIDTH-1:0] din_char,
  input  logic [ATTR_WIDTH-1:0] din_attr,
  input  logic [COL_WIDTH-1:0]  col_r,
  input  logic [ROW_WIDTH-1:0]  row_r,
  output logic [CHAR_WIDTH-1:0] dout_char,
  output logic [ATTR_WIDTH-1:0] dout_attr,
  input  logic                  clr_req,
  input  logic                  scroll_req,
  input  logic [CHAR_WIDTH-1:0] fill_char,
  input  logic [ATTR_WIDTH-1:0] fill_attr,
  output logic                  busy
);

  localparam int ADDR_WIDTH = $clog2(NUM_TILES);
  localparam logic [COL_WIDTH:0]    H_LIM     = (COL_WIDTH+1)'(H_TILES);
  localparam logic [ROW_WIDTH:0]    V_LIM     = (ROW_WIDTH+1)'(V_TILES);
  localparam logic [ROW_WIDTH-1:0]  LAST_ROW  = ROW_WIDTH'(V_TILES - 1);
  localparam logic [ROW_WIDTH-1:0]  ROW_ONE   = {{(ROW_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] LAST_TILE = ADDR_WIDTH'(NUM_TILES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_COL  = ADDR_WIDTH'(H_TILES - 1);
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [ADDR_WIDTH-1:0] tile_addr(input logic [ROW_WIDTH-1:0]  prow,
                                                      input logic [ADDR_WIDTH-1:0] col);
    return ADDR_WIDTH'(prow) * ADDR_WIDTH'(H_TILES) + col;
  endfunction

  state_e                  state_q;
  logic                    busy_q;
  logic [ROW_WIDTH-1:0]    offset_q;
  logic [ROW_WIDTH-1:0]    offset_d;
  logic [ROW_WIDTH-1:0]    scroll_row_q;
  logic [ADDR_WIDTH-1:0]   cnt_q;
  logic [CHAR_WIDTH-1:0]   fill_char_q;
  logic [ATTR_WIDTH-1:0]   fill_attr_q;

  logic                    rd_ok_s;
  logic [ROW_WIDTH-1:0]    rd_row_s;
  logic [ADDR_WIDTH-1:0]   rd_addr_s;
  logic                    wr_ok_s;
  logic [ROW_WIDTH-1:0]    wr_row_s;
  logic [ADDR_WIDTH-1:0]   wr_addr_s;
  logic                    we_s;
  logic [ADDR_WIDTH-1:0]   waddr_s;
  logic [TILE_WIDTH-1:0]   wdata_s;
  logic [TILE_WIDTH-1:0]   rdata_s;

  assign offset_d  = (offset_q == LAST_ROW) ? {ROW_WIDTH{1'b0}} : offset_q + ROW_ONE;

  assign rd_ok_s   = ({1'b0, col_r} < H_LIM) && ({1'b0, row_r} < V_LIM);
  assign rd_row_s  = wrap_row({1'b0, row_r} + {1'b0, offset_q}, V_LIM);
  assign rd_addr_s = tile_addr(rd_row_s, ADDR_WIDTH'(col_r));

  assign wr_ok_s   = wr_en && ({1'b0, col_w} < H_LIM) && ({1'b0, row_w} < V_LIM);
  assign wr_row_s  = wrap_row({1'b0, row_w} + {1'b0, offset_q}, V_LIM);
  assign wr_addr_s = tile_addr(wr_row_s, ADDR_WIDTH'(col_w));

  // Write-port arbitration: the engine owns the port whenever it is not idle.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = {ADDR_WIDTH{1'b0}};
    wdata_s = {fill_char_q, fill_attr_q};
    case (state_q)
      IDLE: begin
        we_s    = wr_ok_s;
        waddr_s = wr_addr_s;
        wdata_s = {din_char, din_attr};
      end
      CLEAR: begin
        we_s    = 1'b1;
        waddr_s = cnt_q;
      end
      SCROLL: begin
        we_s    = 1'b1;
        waddr_s = tile_addr(scroll_row_q, cnt_q);
      end
      default: begin
        we_s    = 1'b0;
      end
    endcase
  end

  // Engine FSM, row offset and fill counter; clear has priority over scroll.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      offset_q     <= {ROW_WIDTH{1'b0}};
      scroll_row_q <= {ROW_WIDTH{1'b0}};
      cnt_q        <= {ADDR_WIDTH{1'b0}};
      fill_char_q  <= {CHAR_WIDTH{1'b0}};
      fill_attr_q  <= {ATTR_WIDTH{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= {ADDR_WIDTH{1'b0}};
          if (clr_req) begin
            state_q     <= CLEAR;
            busy_q      <= 1'b1;
            offset_q    <= {ROW_WIDTH{1'b0}};
            fill_char_q <= fill_char;
            fill_attr_q <= fill_attr;
          end else if (scroll_req) begin
            state_q      <= SCROLL;
            busy_q       <= 1'b1;
            scroll_row_q <= offset_q;
            offset_q     <= offset_d;
            fill_char_q  <= fill_char;
            fill_attr_q  <= fill_attr;
          end else begin
            busy_q <= 1'b0;
          end
        end
        CLEAR: begin
          if (cnt_q == LAST_TILE) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= {ADDR_WIDTH{1'b0}};
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
          end
        end
        SCROLL: begin
          if (cnt_q == LAST_COL) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= {ADDR_WIDTH{1'b0}};
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= {ADDR_WIDTH{1'b0}};
        end
      endcase
    end
  end

  text_buffer_tile_ram #(
    .DEPTH (NUM_TILES),
    .AW    (ADDR_WIDTH),
    .DW    (TILE_WIDTH)
  ) u_tile_ram (
    .clk      (clk),
    .rst      (rst),
    .we_i     (we_s),
    .waddr_i  (waddr_s),
    .wdata_i  (wdata_s),
    .rvalid_i (rd_ok_s),
    .raddr_i  (rd_addr_s),
    .rdata_o  (rdata_s)
  );

  assign dout_char = rdata_s[TILE_WIDTH-1:ATTR_WIDTH];
  assign dout_attr = rdata_s[ATTR_WIDTH-1:0];
  assign busy      = busy_q;

endmodule

// File: tb/tb_text_buffer.sv
// Self-checking bench for text_buffer: a logical screen model feeds a queue of
// expected read data that each test pops and compares as the DUT answers.
module tb_text_buffer;

  localparam int H = 80;
  localparam int V = 30;
  localparam int N = H * V;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [6:0] col_w;
  logic [4:0] row_w;
  logic [6:0] din_char;
  logic [7:0] din_attr;
  logic [6:0] col_r;
  logic [4:0] row_r;
  logic [6:0] dout_char;
  logic [7:0] dout_attr;
  logic       clr_req;
  logic       scroll_req;
  logic [6:0] fill_char;
  logic [7:0] fill_attr;
  logic       busy;

  logic [6:0]  m_char [V][H];
  logic [7:0]  m_attr [V][H];
  logic [14:0] exp_q [$];
  logic [14:0] exp_v;
  int          checks = 0;
  int          errors = 0;
  int          n;

  text_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .col_w      (col_w),
    .row_w      (row_w),
    .din_char   (din_char),
    .din_attr   (din_attr),
    .col_r      (col_r),
    .row_r      (row_r),
    .dout_char  (dout_char),
    .dout_attr  (dout_attr),
    .clr_req    (clr_req),
    .scroll_req (scroll_req),
    .fill_char  (fill_char),
    .fill_attr  (fill_attr),
    .busy       (busy)
  );

  always #20 clk = ~clk;

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_fill(input logic [6:0] c, input logic [7:0] a);
    for (int r = 0; r < V; r++)
      for (int k = 0; k < H; k++) begin
        m_char[r][k] = c;
        m_attr[r][k] = a;
      end
  endtask

  task automatic model_scroll(input logic [6:0] c, input logic [7:0] a);
    for (int r = 0; r < V - 1; r++)
      for (int k = 0; k < H; k++) begin
        m_char[r][k] = m_char[r+1][k];
        m_attr[r][k] = m_attr[r+1][k];
      end
    for (int k = 0; k < H; k++) begin
      m_char[V-1][k] = c;
      m_attr[V-1][k] = a;
    end
  endtask

  // Drives a read address and queues the data the model says must come back.
  task automatic issue_read(input int r, input int c);
    row_r = r[4:0];
    col_r = c[6:0];
    if (r < V && c < H) exp_q.push_back({m_char[r][c], m_attr[r][c]});
    else                exp_q.push_back(15'h0000);
  endtask

  task automatic host_write(input int r, input int c, input logic [6:0] ch, input logic [7:0] at);
    row_w = r[4:0]; col_w = c[6:0]; din_char = ch; din_attr = at; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    if (r < V && c < H) begin
      m_char[r][c] = ch;
      m_attr[r][c] = at;
    end
  endtask

  task automatic engine_req(input logic clr, input logic scr, input logic [6:0] fc, input logic [7:0] fa);
    clr_req = clr; scroll_req = scr; fill_char = fc; fill_attr = fa;
    tick();
    clr_req = 1'b0; scroll_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; clr_req = 1'b0; scroll_req = 1'b0;
    col_w = 7'd0; row_w = 5'd0; din_char = 7'd0; din_attr = 8'd0;
    col_r = 7'd0; row_r = 5'd0; fill_char = 7'd0; fill_attr = 8'd0;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if ({dout_char, dout_attr} !== 15'h0000) begin
      errors++; $display("FAIL reset_dout: got %h/%h want 00/00", dout_char, dout_attr);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    host_write(3, 5, 7'h41, 8'h1F);
    issue_read(3, 5); tick();
    exp_v = exp_q.pop_front(); checks++;
    if ({dout_char, dout_attr} !== exp_v) begin
      errors++; $display("FAIL write_read: got %h/%h want %h/%h", dout_char, dout_attr, exp_v[14:8], exp_v[7:0]);
    end
    // Same-address read during a write must return the previous contents.
    issue_read(3, 5);
    host_write(3, 5, 7'h43, 8'h2F);
    exp_v = exp_q.pop_front(); checks++;
    if ({dout_char, dout_attr} !== exp_v) begin
      errors++; $display("FAIL read_during_write: got %h/%h want %h/%h", dout_char, dout_attr, exp_v[14:8], exp_v[7:0]);
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 0) issue_read(3, 5);
      else if (i == 1) issue_read(3, 80);
      else issue_read(30, 2);
      tick();
      exp_v = exp_q.pop_front(); checks++;
      if ({dout_char, dout_attr} !== exp_v) begin
        errors++; $display("FAIL read_range_%0d: got %h/%h want %h/%h", i, dout_char, dout_attr, exp_v[14:8], exp_v[7:0]);
      end
    end
  endtask

  task automatic test_clear();
    engine_req(1'b1, 1'b0, 7'h20, 8'h07);
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      // Host write and engine requests while busy must all be ignored.
      if (n == 100) begin row_w = 5'd3; col_w = 7'd5; din_char = 7'h55; din_attr = 8'h66; wr_en = 1'b1; end
      else wr_en = 1'b0;
      clr_req    = (n == 200);
      scroll_req = (n == 300);
      tick();
      n++;
    end
    wr_en = 1'b0; clr_req = 1'b0; scroll_req = 1'b0;
    checks++;
    if (n != N) begin errors++; $display("FAIL clear_busy_cycles: got %0d want %0d", n, N); end
    model_fill(7'h20, 8'h07);
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL clear_no_requeue: got busy %b want 0", busy); end
    host_write(3, 80, 7'h7E, 8'hEE);
    host_write(30, 0, 7'h7D, 8'hDD);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++) begin
        issue_read(r, c); tick();
        exp_v = exp_q.pop_front(); checks++;
        if ({dout_char, dout_attr} !== exp_v) begin
          errors++; $display("FAIL clear_scan r%0d c%0d: got %h/%h want %h/%h", r, c, dout_char, dout_attr, exp_v[14:8], exp_v[7:0]);
        end
      end
  endtask

  task automatic test_scroll();
    host_write(0, 0, 7'h41, 8'h1F);
    host_write(1, 0, 7'h42, 8'h2E);
    host_write(29, 10, 7'h5A, 8'h33);
    host_write(29, 79, 7'h5B, 8'h34);
    engine_req(1'b0, 1'b1, 7'h20, 8'h07);
    n = 0;
    while (busy === 1'b1 && n < 3000) begin tick(); n++; end
    checks++;
    if (n != H) begin errors++; $display("FAIL scroll_busy_cycles: got %0d want %0d", n, H); end
    model_scroll(7'h20, 8'h07);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++) begin
        issue_read(r, c); tick();
        exp_v = exp_q.pop_front(); checks++;
        if ({dout_char, dout_attr} !== exp_v) begin
          errors++; $display("FAIL scroll_scan r%0d c%0d: got %h/%h want %h/%h", r, c, dout_char, dout_attr, exp_v[14:8], exp_v[7:0]);
        end
      end
  endtask

  task automatic test_scroll_wrap();
    engine_req(1'b1, 1'b0, 7'h20, 8'h07);
    n = 0;
    while (busy === 1'b1 && n < 3000) begin tick(); n++; end
    checks++;
    if (n != N) begin errors++; $display("FAIL wrap_clear_cycles: got %0d want %0d", n, N); end
    model_fill(7'h20, 8'h07);
    for (int s = 0; s < 31; s++) begin
      engine_req(1'b0, 1'b1, 7'h2E, 8'h1A);
      n = 0;
      while (busy === 1'b1 && n < 3000) begin tick(); n++; end
      checks++;
      if (n != H) begin errors++; $display("FAIL wrap_scroll_%0d_cycles: got %0d want %0d", s, n, H); end
      model_scroll(7'h2E, 8'h1A);
    end
    host_write(29, 79, 7'h7F, 8'hA5);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++) begin
        issue_read(r, c); tick();
        exp_v = exp_q.pop_front(); checks++;
        if ({dout_char, dout_attr} !== exp_v) begin
          errors++; $display("FAIL wrap_scan r%0d c%0d: got %h/%h want %h/%h", r, c, dout_char, dout_attr, exp_v[14:8], exp_v[7:0]);
        end
      end
  endtask

  task automatic test_back_to_back();
    engine_req(1'b1, 1'b1, 7'h31, 8'h42);
    n = 0;
    while (busy === 1'b1 && n < 3000) begin tick(); n++; end
    checks++;
    if (n != N) begin errors++; $display("FAIL collide_busy_cycles: got %0d want %0d", n, N); end
    model_fill(7'h31, 8'h42);
    host_write(0, 0, 7'h41, 8'h11);
    host_write(1, 0, 7'h42, 8'h22);
    engine_req(1'b0, 1'b1, 7'h33, 8'h44);
    n = 0;
    while (busy === 1'b1 && n < 3000) begin tick(); n++; end
    checks++;
    if (n != H) begin errors++; $display("FAIL collide_scroll_cycles: got %0d want %0d", n, H); end
    model_scroll(7'h33, 8'h44);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++) begin
        issue_read(r, c); tick();
        exp_v = exp_q.pop_front(); checks++;
        if ({dout_char, dout_attr} !== exp_v) begin
          errors++; $display("FAIL collide_scan r%0d c%0d: got %h/%h want %h/%h", r, c, dout_char, dout_attr, exp_v[14:8], exp_v[7:0]);
        end
      end
  endtask

  task automatic test_reset_mid_clear();
    row_r = 5'd0; col_r = 7'd0;
    engine_req(1'b1, 1'b0, 7'h20, 8'h07);
    repeat (1000) tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midclear_busy: got %b want 1", busy); end
    checks++;
    if ({dout_char, dout_attr} !== {7'h20, 8'h07}) begin
      errors++; $display("FAIL midclear_read: got %h/%h want 20/07", dout_char, dout_attr);
    end
    rst = 1'b1;
    #2;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL async_rst_busy: got %b want 0", busy); end
    checks++;
    if ({dout_char, dout_attr} !== 15'h0000) begin
      errors++; $display("FAIL async_rst_dout: got %h/%h want 00/00", dout_char, dout_attr);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    engine_req(1'b1, 1'b0, 7'h55, 8'h66);
    n = 0;
    while (busy === 1'b1 && n < 3000) begin tick(); n++; end
    checks++;
    if (n != N) begin errors++; $display("FAIL post_rst_clear_cycles: got %0d want %0d", n, N); end
    model_fill(7'h55, 8'h66);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++) begin
        issue_read(r, c); tick();
        exp_v = exp_q.pop_front(); checks++;
        if ({dout_char, dout_attr} !== exp_v) begin
          errors++; $display("FAIL post_rst_scan r%0d c%0d: got %h/%h want %h/%h", r, c, dout_char, dout_attr, exp_v[14:8], exp_v[7:0]);
        end
      end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_clear();
    test_scroll();
    test_scroll_wrap();
    test_back_to_back();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
